// File: rtl/i2s_transmitter_if.sv
// rtl/i2s_transmitter_if.sv - stereo sample handshake between the sum stage and the I2S transmitter
interface i2s_transmitter_if;
    logic [15:0] sample_l_in;
    logic [15:0] sample_r_in;
    logic        sample_valid_in;
    logic        sample_ready_out;

    modport master (
        output sample_l_in,
        output sample_r_in,
        output sample_valid_in,
        input  sample_ready_out
    );

    modport slave (
        input  sample_l_in,
        input  sample_r_in,
        input  sample_valid_in,
        output sample_ready_out
    );
endinterface

// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - 16-bit stereo I2S serialiser with one-pair holding buffer and underrun tracking
module i2s_transmitter #(
    parameter int CLK_DIV = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    i2s_transmitter_if.slave     s,
    output logic                 i2s_bclk_out,
    output logic                 i2s_lrclk_out,
    output logic                 i2s_sdata_out,
    output logic                 frame_start_out,
    output logic                 underrun_out,
    output logic [7:0]           underrun_count_out
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0]  div_cnt;
    logic [4:0]  slot;
    logic [31:0] frame_q;
    logic [31:0] buf_q;
    logic        buf_full;

    logic        bclk_tick;
    logic        fall_tick;
    logic [4:0]  slot_nxt;
    logic [4:0]  bit_idx;
    logic        load;
    logic        accept;

    assign bclk_tick  = (div_cnt == DIV_LAST);
    assign fall_tick  = bclk_tick && i2s_bclk_out;
    assign slot_nxt   = slot + 5'd1;
    // Slot n carries frame bit 32-n; slot 0 instead re-sends the old frame's LSB.
    assign bit_idx    = 5'd0 - slot_nxt;
    assign load       = fall_tick && (slot_nxt == 5'd0);
    assign accept     = s.sample_valid_in && !buf_full;

    assign s.sample_ready_out = !buf_full;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            div_cnt            <= 8'd0;
            slot               <= 5'd31;
            frame_q            <= 32'h0;
            buf_q              <= 32'h0;
            buf_full           <= 1'b0;
            i2s_bclk_out       <= 1'b0;
            i2s_lrclk_out      <= 1'b1;
            i2s_sdata_out      <= 1'b0;
            frame_start_out    <= 1'b0;
            underrun_out       <= 1'b0;
            underrun_count_out <= 8'd0;
        end else begin
            frame_start_out <= 1'b0;
            underrun_out    <= 1'b0;

            if (bclk_tick) begin
                div_cnt      <= 8'd0;
                i2s_bclk_out <= ~i2s_bclk_out;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end

            if (fall_tick) begin
                slot          <= slot_nxt;
                i2s_lrclk_out <= slot_nxt[4];
                if (slot_nxt == 5'd0) begin
                    i2s_sdata_out <= frame_q[0];
                end else begin
                    i2s_sdata_out <= frame_q[bit_idx];
                end
            end

            if (load) begin
                frame_start_out <= 1'b1;
                if (buf_full) begin
                    frame_q <= buf_q;
                end else begin
                    frame_q      <= 32'h0;
                    underrun_out <= 1'b1;
                    if (underrun_count_out != 8'hFF) begin
                        underrun_count_out <= underrun_count_out + 8'd1;
                    end
                end
            end

            // A pair written during the load cycle is kept for the next frame, never bypassed.
            if (load) begin
                buf_full <= accept;
            end else if (accept) begin
                buf_full <= 1'b1;
            end

            if (accept) begin
                buf_q <= {s.sample_l_in, s.sample_r_in};
            end
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb/tb_i2s_transmitter.sv - self-checking bench for i2s_transmitter against a slot-timing reference model
module tb_i2s_transmitter;

    localparam int D = 2;
    localparam int FRAME = 64 * D;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       bclk, lrclk, sdata, fs, ur;
    logic [7:0] ucnt;

    i2s_transmitter_if sif ();

    i2s_transmitter #(.CLK_DIV(D)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .s                  (sif.slave),
        .i2s_bclk_out       (bclk),
        .i2s_lrclk_out      (lrclk),
        .i2s_sdata_out      (sdata),
        .frame_start_out    (fs),
        .underrun_out       (ur),
        .underrun_count_out (ucnt)
    );

    always #5 clk_in = ~clk_in;

    int          tests = 0;
    int          fails = 0;
    int          c;
    bit          m_full;
    logic [31:0] m_buf;
    logic [31:0] m_frames[$];
    int          m_ucnt;
    logic [63:0] cap_d;
    logic [63:0] cap_lr;
    int          acc_obs;
    int          ur_obs;
    int          first_fs;
    bit          acc;
    logic [15:0] cur_l, cur_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, c);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".bclk"},  {31'd0, bclk},  32'd0);
        chk({tag, ".lrclk"}, {31'd0, lrclk}, 32'd1);
        chk({tag, ".sdata"}, {31'd0, sdata}, 32'd0);
        chk({tag, ".fs"},    {31'd0, fs},    32'd0);
        chk({tag, ".ur"},    {31'd0, ur},    32'd0);
        chk({tag, ".ucnt"},  {24'd0, ucnt},  32'd0);
        chk({tag, ".ready"}, {31'd0, sif.sample_ready_out}, 32'd1);
    endtask

    task automatic release_reset();
        sif.sample_valid_in = 1'b0;
        sif.sample_l_in     = 16'h0;
        sif.sample_r_in     = 16'h0;
        rst_in   = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        chk_reset("reset");
        rst_in   = 1'b0;
        c        = 0;
        m_full   = 1'b0;
        m_buf    = 32'h0;
        m_frames.delete();
        m_ucnt   = 0;
        cap_d    = 64'h0;
        cap_lr   = 64'h0;
        acc_obs  = 0;
        ur_obs   = 0;
        first_fs = -1;
    endtask

    // One clock: drive inputs, advance, then compare every output with the slot-timing model.
    task automatic step(input bit v, input logic [15:0] l, input logic [15:0] r, output bit accepted);
        bit          exp_ready, load, exp_ur, exp_sd, prev_bclk;
        int          k, slot, f;
        logic [31:0] fr;
        sif.sample_valid_in = v;
        sif.sample_l_in     = l;
        sif.sample_r_in     = r;
        exp_ready = !m_full;
        chk("ready", {31'd0, sif.sample_ready_out}, {31'd0, exp_ready});
        if (v && sif.sample_ready_out) acc_obs++;
        accepted  = v && exp_ready;
        prev_bclk = bclk;
        @(posedge clk_in);
        #1;
        c++;
        load   = (c >= 2 * D) && (((c - 2 * D) % FRAME) == 0);
        exp_ur = 1'b0;
        if (load) begin
            m_frames.push_back(m_full ? m_buf : 32'h0);
            exp_ur = !m_full;
            if (!m_full && m_ucnt < 255) m_ucnt++;
            m_full = accepted;
        end else if (accepted) begin
            m_full = 1'b1;
        end
        if (accepted) m_buf = {l, r};
        k    = c / (2 * D);
        slot = (31 + k) % 32;
        f    = m_frames.size();
        exp_sd = 1'b0;
        if (slot == 0) begin
            if (f >= 2) begin fr = m_frames[f - 2]; exp_sd = fr[0]; end
        end else if (f >= 1) begin
            fr = m_frames[f - 1];
            exp_sd = fr[32 - slot];
        end
        chk("bclk",  {31'd0, bclk},  32'((c / D) % 2));
        chk("lrclk", {31'd0, lrclk}, {31'd0, (slot >= 16)});
        chk("sdata", {31'd0, sdata}, {31'd0, exp_sd});
        chk("frame_start", {31'd0, fs}, {31'd0, load});
        chk("underrun", {31'd0, ur}, {31'd0, exp_ur});
        chk("underrun_count", {24'd0, ucnt}, 32'(m_ucnt));
        if (fs && first_fs < 0) first_fs = c;
        if (ur) ur_obs++;
        if (!prev_bclk && bclk) begin
            cap_d  = {cap_d[62:0], sdata};
            cap_lr = {cap_lr[62:0], lrclk};
        end
    endtask

    task automatic idle_until(input int target);
        bit a;
        while (c < target) step(1'b0, 16'h0, 16'h0, a);
    endtask

    initial begin
        sif.sample_valid_in = 1'b0;
        sif.sample_l_in     = 16'h0;
        sif.sample_r_in     = 16'h0;

        // Known pair written before the first load, captured at bclk rises.
        release_reset();
        step(1'b1, 16'hA5C3, 16'h3C5A, acc);
        idle_until(2 * D + FRAME + D);
        chk("first_fs_cycle", 32'(first_fs), 32'(2 * D));
        chk("known_frame_bits", cap_d[31:0], 32'hA5C33C5A);
        chk("known_frame_lrclk", cap_lr[31:0], 32'h0001FFFE);

        // No write before the first load: silent frame with underrun.
        release_reset();
        idle_until(2 * D);
        chk("silence_fs", {31'd0, fs}, 32'd1);
        chk("silence_ur", {31'd0, ur}, 32'd1);
        chk("silence_ucnt", {24'd0, ucnt}, 32'd1);
        idle_until(2 * D + FRAME + D);
        chk("silence_bits", cap_d[31:0], 32'h0);

        // Valid held high with random pairs: one accept per frame, no underruns.
        release_reset();
        cur_l = 16'($urandom);
        cur_r = 16'($urandom);
        while (c < 2 * D + 9 * FRAME) begin
            step(1'b1, cur_l, cur_r, acc);
            if (acc) begin
                cur_l = 16'($urandom);
                cur_r = 16'($urandom);
            end
        end
        chk("stream_accepts", 32'(acc_obs), 32'd10);
        chk("stream_underruns", 32'(ur_obs), 32'd0);
        idle_until(2 * D + 10 * FRAME + D);

        // Write landing exactly on the load edge goes to the following frame.
        release_reset();
        idle_until(2 * D - 1);
        cur_l = 16'($urandom);
        cur_r = 16'($urandom);
        step(1'b1, cur_l, cur_r, acc);
        chk("coincident_ur", {31'd0, ur}, 32'd1);
        chk("coincident_ready", {31'd0, sif.sample_ready_out}, 32'd0);
        idle_until(2 * D + 2 * FRAME + D);
        chk("coincident_next_frame", cap_d[31:0], {cur_l, cur_r});

        // Long underrun run saturates the counter; reset clears it.
        release_reset();
        idle_until(2 * D + 299 * FRAME + 1);
        chk("sat_count", {24'd0, ucnt}, 32'd255);
        chk("sat_underruns", 32'(ur_obs), 32'd300);
        rst_in = 1'b1;
        #1;
        chk("sat_cleared", {24'd0, ucnt}, 32'd0);

        // Reset in slot 9 with a pair buffered: async clear, fresh timing after release.
        release_reset();
        step(1'b1, 16'($urandom), 16'($urandom), acc);
        idle_until(2 * D + 1);
        step(1'b1, 16'($urandom), 16'($urandom), acc);
        idle_until(10 * 2 * D);
        chk("pre_reset_full", {31'd0, sif.sample_ready_out}, 32'd0);
        chk("pre_reset_bclk", {31'd0, bclk}, 32'd0);
        #2;
        rst_in = 1'b1;
        #1;
        chk_reset("async_reset");
        release_reset();
        idle_until(2 * D + D);
        chk("post_reset_fs_cycle", 32'(first_fs), 32'(2 * D));
        chk("post_reset_discard_ur", 32'(ur_obs), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
